hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined datapath.
- Keeps a shadow copy of the destination and control state for the EX, MEM and WB stages.
- Generates the two 2-bit forwarding selects (fwdr1, fwdr2) for the ID-stage operand muxes.
- Detects load-use hazards and sequences stalls, bubbles and branch flushes through a small FSM.
- Sits beside the datapath and the instruction-fetch unit; drives PC hold, IF/ID hold and bubble injection.

Parameters:
- ZERO_REG, 31, register index hardwired to zero; never a forwarding or hazard match.
- FLUSH_CYCLES, 1, number of cycles IF/ID is squashed after a taken branch (1..3).
- CNT_W, 16, width of the saturating stall/flush performance counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rn  in  5  ID-stage first source register (instruction[9:5])
- id_rm  in  5  ID-stage second source register (Reg2Loc-muxed)
- id_use_rn  in  1  ID instruction reads id_rn
- id_use_rm  in  1  ID instruction reads id_rm (includes CBZ test operand)
- id_rd  in  5  ID-stage destination register
- id_regwrite  in  1  ID instruction writes the register file
- id_memtoreg  in  1  ID instruction is a load
- br_taken  in  1  branch resolved taken in ID (valid only when not stalling)
- fwdr1  out  2  operand A forwarding select: 0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB register
- fwdr2  out  2  operand B forwarding select; same encoding as fwdr1
- pc_hold  out  1  freeze PC and IF/ID register
- bubble  out  1  force RegWrite/MemWrite/MemToReg to 0 into ID/EX
- flush_if  out  1  squash the IF/ID instruction (convert to NOP)
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Shadow pipeline, updated each rising clk edge:
  - EX stage ← ID values {rd, regwrite, memtoreg}, with regwrite and memtoreg forced to 0 when bubble=1.
  - MEM stage ← EX stage; WB stage ← MEM stage.
- Forwarding (combinational, fwdr1 shown; fwdr2 is identical using id_rm and id_use_rm):
  - Select 0 if id_use_rn=0 or id_rn==ZERO_REG.
  - Else select 1 if ex_regwrite, ex_rd==id_rn and ex_memtoreg=0.
  - Else select 2 if mem_regwrite and mem_rd==id_rn.
  - Else select 3 if wb_regwrite and wb_rd==id_rn.
  - Else select 0.
  - Priority is EX > MEM > WB (youngest producer wins).
- Load-use hazard (lu):
  - lu = ex_regwrite & ex_memtoreg & ex_rd!=ZERO_REG & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
  - During lu the fwd select for the dependent operand is don't-care; the next cycle it resolves to 2.
- FSM states: RUN, STALL, FLUSH.
  - RUN, lu=1: pc_hold=1, bubble=1, flush_if=0; next state STALL. br_taken is ignored in this cycle.
  - RUN, lu=0, br_taken=1: flush_if=1. Next state is FLUSH with flush counter = FLUSH_CYCLES-1, or RUN when FLUSH_CYCLES=1.
  - RUN, lu=0, br_taken=0: all control outputs 0; stay in RUN.
  - STALL: load is now in MEM; no outputs asserted; behaves as RUN for this cycle, so lu and br_taken are re-evaluated. A back-to-back load-use (a new load in EX) returns to STALL.
  - FLUSH: flush_if=1; flush counter decrements; return to RUN at 0. lu and br_taken are ignored because squashed slots carry no hazards.
- Counters:
  - stall_cnt increments on each cycle with bubble=1.
  - flush_cnt increments on each cycle with flush_if=1.
  - Both saturate at all-ones and do not wrap.
- Reset (reset=0, asynchronous):
  - State returns to RUN.
  - All shadow-stage regwrite/memtoreg = 0, rd = 0.
  - Counters = 0.
  - Outputs: pc_hold=0, bubble=0, flush_if=0, fwdr1=fwdr2=0.
  - Reset asserted mid-stall or mid-flush aborts immediately; the first cycle after deassertion is RUN with empty shadow stages.
- Simultaneous lu and br_taken: lu wins; the branch re-resolves after the stall.
- Latency: forwarding and hazard outputs are combinational from ID inputs and current state. State and counters update one clk after the triggering condition.

Test Plan:
- ADD X1 in EX, then SUB reading X1,X2 in ID → fwdr1=1, fwdr2=0, no stall.
- LDUR X3 in EX, ADD reading X3 as rm in ID → pc_hold=1 and bubble=1 for exactly 1 cycle. Next cycle fwdr2=2, stall_cnt=1.
- X1 written by instructions in EX, MEM and WB together → fwdr1=1. Kill EX regwrite → fwdr1=2. Kill MEM regwrite as well → fwdr1=3.
- Write to X31 pending in EX/MEM while ID reads X31 → fwdr1=fwdr2=0, no stall even with a load.
- FLUSH_CYCLES=2, br_taken pulse → flush_if high for 2 cycles, flush_cnt=2. Concurrent lu and br_taken → stall first, no flush that cycle.
- Assert reset during STALL → outputs 0 asynchronously. After release, a load-use pair stalls normally. Force stall_cnt to 0xFFFF → it stays at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundle of the ID-stage hazard inputs and the forwarding / pipeline
//          control outputs exchanged between the datapath and hazard_ctrl.
// Signals:
//   id_rn, id_rm        ID source register indices
//   id_use_rn, id_use_rm  ID instruction actually reads the source
//   id_rd               ID destination register index
//   id_regwrite         ID instruction writes the register file
//   id_memtoreg         ID instruction is a load
//   br_taken            branch resolved taken in ID
//   fwdr1, fwdr2        operand forwarding selects (0 regfile, 1 EX, 2 MEM, 3 WB)
//   pc_hold             freeze PC and IF/ID
//   bubble              inject a bubble into ID/EX
//   flush_if            squash the IF/ID instruction
//   stall_cnt, flush_cnt  saturating performance counters
// Modports: master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             br_taken;
  logic [1:0]       fwdr1;
  logic [1:0]       fwdr2;
  logic             pc_hold;
  logic             bubble;
  logic             flush_if;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_regwrite, id_memtoreg, br_taken,
    input  fwdr1, fwdr2, pc_hold, bubble, flush_if, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm, id_rd, id_regwrite, id_memtoreg, br_taken,
    output fwdr1, fwdr2, pc_hold, bubble, flush_if, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: hazard and forwarding controller for the 5-stage pipeline. Tracks a
//          shadow copy of EX/MEM/WB destination state, produces operand
//          forwarding selects, detects load-use hazards and sequences stalls
//          and branch flushes.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hazard_ctrl_if.slave: ID-stage inputs, forwarding selects,
//          pc_hold / bubble / flush_if controls and performance counters
module hazard_ctrl #(
  parameter int ZERO_REG     = 31,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0]       ZR         = 5'(ZERO_REG);
  localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [1:0]       flush_left_r, flush_left_nxt_s;
  logic [4:0]       ex_rd_r, mem_rd_r, wb_rd_r;
  logic             ex_rw_r, mem_rw_r, wb_rw_r;
  logic             ex_mt_r;
  logic             lu_s;
  logic             pc_hold_s, bubble_s, flush_if_s;
  logic [1:0]       fwdr1_s, fwdr2_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Youngest producer wins; a load in EX cannot forward (its data is not ready yet).
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       use_src,
    input logic [4:0] ex_rd,
    input logic       ex_rw,
    input logic       ex_mt,
    input logic [4:0] mem_rd,
    input logic       mem_rw,
    input logic [4:0] wb_rd,
    input logic       wb_rw
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (!use_src || (src == ZR)) begin
      sel = 2'd0;
    end else if (ex_rw && (ex_rd == src) && !ex_mt) begin
      sel = 2'd1;
    end else if (mem_rw && (mem_rd == src)) begin
      sel = 2'd2;
    end else if (wb_rw && (wb_rd == src)) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Load-use detection and operand forwarding selects.
  always_comb begin
    lu_s    = ex_rw_r && ex_mt_r && (ex_rd_r != ZR) &&
              ((bus.id_use_rn && (bus.id_rn == ex_rd_r)) ||
               (bus.id_use_rm && (bus.id_rm == ex_rd_r)));
    fwdr1_s = fwd_sel(bus.id_rn, bus.id_use_rn, ex_rd_r, ex_rw_r, ex_mt_r,
                      mem_rd_r, mem_rw_r, wb_rd_r, wb_rw_r);
    fwdr2_s = fwd_sel(bus.id_rm, bus.id_use_rm, ex_rd_r, ex_rw_r, ex_mt_r,
                      mem_rd_r, mem_rw_r, wb_rd_r, wb_rw_r);
  end

  // Stall/flush sequencer: next state and control outputs.
  always_comb begin
    state_nxt_s      = state_r;
    flush_left_nxt_s = flush_left_r;
    pc_hold_s        = 1'b0;
    bubble_s         = 1'b0;
    flush_if_s       = 1'b0;
    case (state_r)
      // STALL only marks that the load has moved to MEM; hazards are re-evaluated as in RUN.
      RUN, STALL: begin
        if (lu_s) begin
          pc_hold_s   = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = STALL;
        end else if (bus.br_taken) begin
          flush_if_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt_s      = FLUSH;
            flush_left_nxt_s = FLUSH_INIT;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      // Squashed slots carry no hazards, so lu and br_taken are not looked at here.
      FLUSH: begin
        flush_if_s = 1'b1;
        if (flush_left_r <= 2'd1) begin
          state_nxt_s      = RUN;
          flush_left_nxt_s = 2'd0;
        end else begin
          state_nxt_s      = FLUSH;
          flush_left_nxt_s = flush_left_r - 2'd1;
        end
      end
      default: begin
        state_nxt_s      = RUN;
        flush_left_nxt_s = 2'd0;
      end
    endcase
  end

  // State, shadow pipeline and saturating counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= RUN;
      flush_left_r <= 2'd0;
      ex_rd_r      <= 5'd0;
      ex_rw_r      <= 1'b0;
      ex_mt_r      <= 1'b0;
      mem_rd_r     <= 5'd0;
      mem_rw_r     <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_rw_r      <= 1'b0;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      flush_left_r <= flush_left_nxt_s;
      ex_rd_r      <= bus.id_rd;
      ex_rw_r      <= bus.id_regwrite && !bubble_s;
      ex_mt_r      <= bus.id_memtoreg && !bubble_s;
      mem_rd_r     <= ex_rd_r;
      mem_rw_r     <= ex_rw_r;
      wb_rd_r      <= mem_rd_r;
      wb_rw_r      <= mem_rw_r;
      if (bubble_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_if_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.fwdr1     = fwdr1_s;
  assign bus.fwdr2     = fwdr2_s;
  assign bus.pc_hold   = pc_hold_s;
  assign bus.bubble    = bubble_s;
  assign bus.flush_if  = flush_if_s;
  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (A: FLUSH_CYCLES=1, 16-bit counters;
// B: FLUSH_CYCLES=2, 3-bit counters) share the same ID-stage stimulus and are
// compared against an instruction-level reference model.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rn, rm, rd;
  logic       urn, urm, rw, mt, br;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  hazard_ctrl_if #(.CNT_W(16)) ifa ();
  hazard_ctrl_if #(.CNT_W(3))  ifb ();

  assign ifa.id_rn = rn;        assign ifb.id_rn = rn;
  assign ifa.id_rm = rm;        assign ifb.id_rm = rm;
  assign ifa.id_use_rn = urn;   assign ifb.id_use_rn = urn;
  assign ifa.id_use_rm = urm;   assign ifb.id_use_rm = urm;
  assign ifa.id_rd = rd;        assign ifb.id_rd = rd;
  assign ifa.id_regwrite = rw;  assign ifb.id_regwrite = rw;
  assign ifa.id_memtoreg = mt;  assign ifb.id_memtoreg = mt;
  assign ifa.br_taken = br;     assign ifb.br_taken = br;

  hazard_ctrl #(.ZERO_REG(31), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  hazard_ctrl #(.ZERO_REG(31), .FLUSH_CYCLES(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, in-flight instructions (slot 0 = EX,
  // 1 = MEM, 2 = WB), remaining squash slots and event counts.
  int         fcyc [2];
  int         cmax [2];
  logic [4:0] m_rd [2][3];
  logic       m_rw [2][3];
  logic       m_mt [2][3];
  int         m_fl [2];
  int         m_sc [2];
  int         m_fc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) begin
        m_rd[k][s] = 5'd0; m_rw[k][s] = 1'b0; m_mt[k][s] = 1'b0;
      end
      m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Search in-flight producers youngest first; a load still in EX cannot supply data.
  function automatic logic [1:0] ref_fwd(input int k, input logic [4:0] r, input logic u);
    if (!u || r == 5'd31) return 2'd0;
    for (int s = 0; s < 3; s++) begin
      if (m_rw[k][s] && m_rd[k][s] == r) begin
        if (s == 0 && m_mt[k][0]) continue;
        return 2'(s + 1);
      end
    end
    return 2'd0;
  endfunction

  function automatic logic ref_lu(input int k);
    logic ld;
    ld = m_rw[k][0] && m_mt[k][0] && (m_rd[k][0] != 5'd31);
    return ld && ((urn && rn == m_rd[k][0]) || (urm && rm == m_rd[k][0]));
  endfunction

  task automatic check_model();
    logic lu, hold, fl;
    logic [1:0] f1, f2;
    logic [31:0] o_hold, o_bub, o_fl, o_f1, o_f2, o_sc, o_fc;
    string nm;
    for (int k = 0; k < 2; k++) begin
      nm   = (k == 0) ? "A" : "B";
      lu   = ref_lu(k);
      hold = (m_fl[k] == 0) && lu;
      fl   = (m_fl[k] > 0) || (!lu && br);
      f1   = ref_fwd(k, rn, urn);
      f2   = ref_fwd(k, rm, urm);
      if (k == 0) begin
        o_hold = 32'(ifa.pc_hold); o_bub = 32'(ifa.bubble); o_fl = 32'(ifa.flush_if);
        o_f1 = 32'(ifa.fwdr1); o_f2 = 32'(ifa.fwdr2);
        o_sc = 32'(ifa.stall_cnt); o_fc = 32'(ifa.flush_cnt);
      end else begin
        o_hold = 32'(ifb.pc_hold); o_bub = 32'(ifb.bubble); o_fl = 32'(ifb.flush_if);
        o_f1 = 32'(ifb.fwdr1); o_f2 = 32'(ifb.fwdr2);
        o_sc = 32'(ifb.stall_cnt); o_fc = 32'(ifb.flush_cnt);
      end
      chk({nm, "_pc_hold"}, o_hold, 32'(hold));
      chk({nm, "_bubble"}, o_bub, 32'(hold));
      chk({nm, "_flush_if"}, o_fl, 32'(fl));
      chk({nm, "_stall_cnt"}, o_sc, 32'(m_sc[k]));
      chk({nm, "_flush_cnt"}, o_fc, 32'(m_fc[k]));
      // Select of an operand waiting on a load is unspecified during the stall cycle.
      if (!hold) begin
        chk({nm, "_fwdr1"}, o_f1, 32'(f1));
        chk({nm, "_fwdr2"}, o_f2, 32'(f2));
      end
    end
  endtask

  task automatic drive(input logic [4:0] a_rn, input logic [4:0] a_rm,
                       input logic a_urn, input logic a_urm,
                       input logic [4:0] a_rd, input logic a_rw,
                       input logic a_mt, input logic a_br);
    rn = a_rn; rm = a_rm; urn = a_urn; urm = a_urm;
    rd = a_rd; rw = a_rw; mt = a_mt; br = a_br;
    #2;
  endtask

  task automatic tick();
    logic lu [2];
    logic bub [2];
    logic fl [2];
    for (int k = 0; k < 2; k++) begin
      lu[k]  = ref_lu(k);
      bub[k] = (m_fl[k] == 0) && lu[k];
      fl[k]  = (m_fl[k] > 0) || (!lu[k] && br);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int s = 2; s > 0; s--) begin
        m_rd[k][s] = m_rd[k][s-1]; m_rw[k][s] = m_rw[k][s-1]; m_mt[k][s] = m_mt[k][s-1];
      end
      m_rd[k][0] = rd; m_rw[k][0] = rw && !bub[k]; m_mt[k][0] = mt && !bub[k];
      if (m_fl[k] > 0) m_fl[k]--;
      else if (fl[k]) m_fl[k] = fcyc[k] - 1;
      if (bub[k] && m_sc[k] < cmax[k]) m_sc[k]++;
      if (fl[k] && m_fc[k] < cmax[k]) m_fc[k]++;
    end
    #1;
  endtask

  function automatic logic [4:0] rreg();
    int s;
    s = $urandom_range(0, 3);
    return (s == 3) ? 5'd31 : 5'(s + 1);
  endfunction

  initial begin
    fcyc[0] = 1; fcyc[1] = 2;
    cmax[0] = 65535; cmax[1] = 7;
    reset = 1'b0;
    rn = 5'd0; rm = 5'd0; urn = 1'b0; urm = 1'b0;
    rd = 5'd0; rw = 1'b0; mt = 1'b0; br = 1'b0;
    model_reset();
    #12;
    check_model();
    chk("rst_pc_hold", 32'(ifa.pc_hold), 32'd0);
    chk("rst_stall_cnt", 32'(ifa.stall_cnt), 32'd0);
    reset = 1'b1;
    tick();

    // ALU producer in EX forwards to the next instruction
    drive(5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0); check_model(); tick();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); check_model();
    chk("alu_fwdr1", 32'(ifa.fwdr1), 32'd1);
    chk("alu_fwdr2", 32'(ifa.fwdr2), 32'd0);
    chk("alu_no_stall", 32'(ifa.pc_hold), 32'd0);
    tick();

    // Load-use on rm: one stall cycle, then MEM forwarding
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); check_model(); tick();
    drive(5'd6, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); check_model();
    chk("lu_pc_hold", 32'(ifa.pc_hold), 32'd1);
    chk("lu_bubble", 32'(ifa.bubble), 32'd1);
    tick();
    drive(5'd6, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); check_model();
    chk("lu_after_hold", 32'(ifa.pc_hold), 32'd0);
    chk("lu_after_fwdr2", 32'(ifa.fwdr2), 32'd2);
    chk("lu_after_stall_cnt", 32'(ifa.stall_cnt), 32'd1);
    tick();

    // X1 in flight in EX, MEM and WB: priority EX > MEM > WB
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0); check_model(); tick();
    end
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); check_model();
    chk("prio_ex", 32'(ifa.fwdr1), 32'd1); tick();
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); check_model();
    chk("prio_mem", 32'(ifa.fwdr1), 32'd2); tick();
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); check_model();
    chk("prio_wb", 32'(ifa.fwdr1), 32'd3); tick();

    // Writes to the zero register never forward or stall
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0); check_model(); tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0); check_model(); tick();
    drive(5'd31, 5'd31, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); check_model();
    chk("zr_fwdr1", 32'(ifa.fwdr1), 32'd0);
    chk("zr_fwdr2", 32'(ifa.fwdr2), 32'd0);
    chk("zr_no_stall", 32'(ifa.pc_hold), 32'd0);
    tick();

    // Taken branch: A flushes one cycle, B two
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); check_model();
    chk("br_A_flush0", 32'(ifa.flush_if), 32'd1);
    chk("br_B_flush0", 32'(ifb.flush_if), 32'd1);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); check_model();
    chk("br_A_flush1", 32'(ifa.flush_if), 32'd0);
    chk("br_B_flush1", 32'(ifb.flush_if), 32'd1);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); check_model();
    chk("br_B_flush2", 32'(ifb.flush_if), 32'd0);
    chk("br_B_flush_cnt", 32'(ifb.flush_cnt), 32'd2);
    tick();

    // Load-use together with a taken branch: stall first, branch re-resolves after
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0); check_model(); tick();
    drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); check_model();
    chk("lubr_hold", 32'(ifb.pc_hold), 32'd1);
    chk("lubr_no_flush", 32'(ifb.flush_if), 32'd0);
    tick();
    drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); check_model();
    chk("lubr_flush_after", 32'(ifb.flush_if), 32'd1);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); check_model(); tick();
    check_model(); tick();

    // Asynchronous reset in the middle of a stall
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); check_model(); tick();
    drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); check_model();
    chk("prerst_hold", 32'(ifa.pc_hold), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("async_rst_hold", 32'(ifa.pc_hold), 32'd0);
    chk("async_rst_bubble", 32'(ifa.bubble), 32'd0);
    chk("async_rst_cnt", 32'(ifa.stall_cnt), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); check_model(); tick();
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); check_model();
    chk("postrst_hold", 32'(ifa.pc_hold), 32'd1);
    tick();

    // Randomized traffic against the model; also drives B's 3-bit counters to saturation
    for (int i = 0; i < 800; i++) begin
      drive(rreg(), rreg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rreg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0));
      check_model();
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check_model();
    chk("B_stall_sat", 32'(ifb.stall_cnt), 32'd7);
    chk("B_flush_sat", 32'(ifb.flush_cnt), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
